// File: rtl/sr_stack_ctrl.sv
// sr_stack_ctrl - CPU hardware stack controller.
//
// Keeps the top DEPTH stack entries in an on-chip circular buffer. A push
// into a full buffer first spills the oldest entry to data memory. A pop
// from an empty buffer first refills the most recently spilled entry. The
// CPU is stalled while either memory transaction is in flight.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   push, pop, push_data  CPU request; held by the CPU while stall is high
//   pop_data              popped value, valid when pop=1 and stall=0
//   stall                 CPU must hold its request and freeze pc
//   mem_req/we/addr/wdata data-memory request (we=1 spill write, 0 fill read)
//   mem_rdata, mem_ack    fill data and one-cycle completion strobe
//   depth, spilled        on-chip entry count, entries held in memory
//   overflow, underflow   sticky error flags, cleared only by reset
module sr_stack_ctrl #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MEM_DEPTH  = 64,
  parameter logic [31:0] SPILL_BASE = 32'h0000_0100
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             push_data,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         stall,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [31:0]                  mem_addr,
  output logic [WIDTH-1:0]             mem_wdata,
  input  logic [WIDTH-1:0]             mem_rdata,
  input  logic                         mem_ack,
  output logic [$clog2(DEPTH):0]       depth,
  output logic [$clog2(MEM_DEPTH):0]   spilled,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = $clog2(MEM_DEPTH) + 1;

  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [SW-1:0] SCNT_FULL = SW'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPILL = 2'd1,
    FILL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    scnt_q, scnt_d;
  logic [PW-1:0]    bot_q, bot_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] buf_q [DEPTH];

  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic [PW-1:0]    top_idx;
  logic [PW-1:0]    push_idx;

  // The low PW bits of cnt wrap to 0 when full, so both indices stay
  // correct modulo DEPTH without special-casing a full buffer.
  assign push_idx = bot_q + cnt_q[PW-1:0];
  assign top_idx  = push_idx - PW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    scnt_d    = scnt_q;
    bot_d     = bot_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    wr_en     = 1'b0;
    wr_idx    = push_idx;
    wr_data   = push_data;
    stall     = 1'b0;
    pop_data  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      IDLE: begin
        if (push && pop) begin
          // Simultaneous push/pop replaces the top in place; on an empty
          // buffer the pushed value is simply forwarded.
          if (cnt_q != '0) begin
            pop_data = buf_q[top_idx];
            wr_en    = 1'b1;
            wr_idx   = top_idx;
          end else begin
            pop_data = push_data;
          end
        end else if (push) begin
          if (cnt_q != CNT_FULL) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end else if (scnt_q != SCNT_FULL) begin
            stall   = 1'b1;
            state_d = SPILL;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (pop) begin
          if (cnt_q != '0) begin
            pop_data = buf_q[top_idx];
            cnt_d    = cnt_q - CW'(1);
          end else if (scnt_q != '0) begin
            stall   = 1'b1;
            state_d = FILL;
          end else begin
            unf_d = 1'b1;
          end
        end
      end

      SPILL: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = SPILL_BASE + (32'(scnt_q) << 2);
        mem_wdata = buf_q[bot_q];
        if (mem_ack) begin
          bot_d   = bot_q + PW'(1);
          cnt_d   = cnt_q - CW'(1);
          scnt_d  = scnt_q + SW'(1);
          state_d = IDLE;
        end
      end

      FILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = SPILL_BASE + (32'(scnt_q - SW'(1)) << 2);
        if (mem_ack) begin
          // Buffer is empty here, so the refilled entry sits at bot and
          // becomes both oldest and top.
          wr_en   = 1'b1;
          wr_idx  = bot_q;
          wr_data = mem_rdata;
          cnt_d   = CW'(1);
          scnt_d  = scnt_q - SW'(1);
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      scnt_q  <= '0;
      bot_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      bot_q   <= bot_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      buf_q[wr_idx] <= wr_data;
    end
  end

  assign depth     = cnt_q;
  assign spilled   = scnt_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_sr_stack_ctrl.sv
// tb_sr_stack_ctrl - bench for sr_stack_ctrl (DEPTH=8, MEM_DEPTH=2).
// A queue holds the whole logical stack; the count of entries living in
// memory decides when a spill or fill must happen. The bench also plays
// the data memory, acknowledging after a chosen number of cycles.
module tb_sr_stack_ctrl;

  localparam int DEPTH     = 8;
  localparam int WIDTH     = 32;
  localparam int MEM_DEPTH = 2;

  logic             clk, rst, push, pop;
  logic [WIDTH-1:0] push_data, pop_data;
  logic             stall, mem_req, mem_we, mem_ack;
  logic [31:0]      mem_addr;
  logic [WIDTH-1:0] mem_wdata, mem_rdata;
  logic [3:0]       depth;
  logic [1:0]       spilled;
  logic             overflow, underflow;

  sr_stack_ctrl #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH),
    .MEM_DEPTH(MEM_DEPTH),
    .SPILL_BASE(32'h0000_0100)
  ) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
    .pop_data(pop_data), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .depth(depth), .spilled(spilled),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] stk[$];
  int          m_s;
  bit          m_ovf, m_unf;
  logic [31:0] mem_m [MEM_DEPTH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    stk.delete();
    m_s   = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; push = 1'b0; pop = 1'b0; mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic check_counts();
    chk("depth",     32'(depth),     32'(stk.size() - m_s));
    chk("spilled",   32'(spilled),   32'(m_s));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask

  // One CPU operation, held through any stall, with the memory answering
  // ack_dly cycles after mem_req rises.
  task automatic do_op(input bit p, input bit q, input logic [31:0] d, input int ack_dly);
    int onchip, kind, nst, rq, guard, slot;
    logic [31:0] exp_pop, exp_addr, exp_wd;
    onchip = stk.size() - m_s;
    kind = 0; exp_pop = '0; exp_addr = '0; exp_wd = '0;
    if (p && q) begin
      exp_pop = (onchip > 0) ? stk[stk.size()-1] : d;
    end else if (p) begin
      if (onchip == DEPTH && m_s < MEM_DEPTH) begin
        kind = 1; exp_addr = 32'h100 + 32'(4 * m_s); exp_wd = stk[m_s];
      end
    end else if (q) begin
      if (onchip > 0) exp_pop = stk[stk.size()-1];
      else if (m_s > 0) begin
        kind = 2; exp_addr = 32'h100 + 32'(4 * (m_s - 1)); exp_pop = stk[m_s-1];
      end
    end

    @(negedge clk);
    push = p; pop = q; push_data = d;
    mem_ack = 1'($urandom_range(0, 1));   // must be ignored while idle
    mem_rdata = $urandom;
    #1;
    nst = 0; rq = 0; guard = 0;
    while (stall === 1'b1 && guard < 40) begin
      nst++; guard++;
      if (mem_req === 1'b1) begin
        chk("mem_we",   32'(mem_we), (kind == 1) ? 32'd1 : 32'd0);
        chk("mem_addr", mem_addr, exp_addr);
        if (kind == 1) chk("mem_wdata", mem_wdata, exp_wd);
        if (rq == ack_dly) begin
          mem_ack = 1'b1;
          slot = int'((mem_addr - 32'h100) >> 2);
          if (slot >= 0 && slot < MEM_DEPTH) begin
            if (mem_we) mem_m[slot] = mem_wdata;
            else        mem_rdata   = mem_m[slot];
          end
        end else begin
          mem_ack = 1'b0;
        end
        rq++;
      end
      @(posedge clk);
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      #1;
    end
    chk("stall_cycles", 32'(nst), (kind != 0) ? 32'(2 + ack_dly) : 32'd0);
    chk("mem_req_idle", 32'(mem_req), 32'd0);
    if (q) chk("pop_data", pop_data, exp_pop);

    if (p && q) begin
      if (onchip > 0) stk[stk.size()-1] = d;
    end else if (p) begin
      if (onchip < DEPTH) stk.push_back(d);
      else if (m_s < MEM_DEPTH) begin m_s++; stk.push_back(d); end
      else m_ovf = 1;
    end else if (q) begin
      if (onchip > 0) void'(stk.pop_back());
      else if (m_s > 0) begin m_s--; void'(stk.pop_back()); end
      else m_unf = 1;
    end

    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; mem_ack = 1'b0;
    check_counts();
  endtask

  initial begin
    int guard, r;
    rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_depth",   32'(depth),    32'd0);
    chk("rst_spilled", 32'(spilled),  32'd0);
    chk("rst_ovf",     32'(overflow), 32'd0);
    chk("rst_unf",     32'(underflow),32'd0);
    chk("rst_memreq",  32'(mem_req),  32'd0);
    chk("rst_stall",   32'(stall),    32'd0);
    chk("rst_popdata", pop_data,      32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Plain LIFO without memory traffic.
    for (int i = 1; i <= 5; i++) do_op(1'b1, 1'b0, 32'(i), 0);
    for (int i = 1; i <= 5; i++) do_op(1'b0, 1'b1, '0, 0);

    // Spill on the ninth push, then drain through a fill.
    for (int i = 1; i <= 9; i++) do_op(1'b1, 1'b0, 32'(i), 2);
    for (int i = 1; i <= 9; i++) do_op(1'b0, 1'b1, '0, 2);

    // Underflow, then push/pop forwarding on an empty stack.
    do_op(1'b0, 1'b1, '0, 0);
    do_op(1'b1, 1'b1, 32'd7, 0);

    // Overflow once buffer and memory are both full.
    do_reset();
    for (int i = 1; i <= 11; i++) do_op(1'b1, 1'b0, 32'(i * 16), 1);
    chk("ovf_set", 32'(overflow), 32'd1);

    // Reset while a spill waits for its ack.
    do_reset();
    for (int i = 1; i <= 8; i++) do_op(1'b1, 1'b0, 32'(100 + i), 0);
    @(negedge clk);
    push = 1'b1; push_data = 32'hdead; mem_ack = 1'b0;
    #1;
    guard = 0;
    while (mem_req !== 1'b1 && guard < 10) begin
      @(posedge clk); @(negedge clk); #1; guard++;
    end
    chk("spill_req_before_rst", 32'(mem_req), 32'd1);
    rst = 1'b1; push = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_spill_memreq",  32'(mem_req), 32'd0);
    chk("rst_spill_depth",   32'(depth),   32'd0);
    chk("rst_spill_spilled", 32'(spilled), 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    chk("late_ack_depth",   32'(depth),   32'd0);
    chk("late_ack_spilled", 32'(spilled), 32'd0);
    chk("late_ack_memreq",  32'(mem_req), 32'd0);
    model_clear();

    // Random mix of pushes, pops and simultaneous push/pop.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5)      do_op(1'b1, 1'b0, $urandom, int'($urandom_range(0, 3)));
      else if (r < 9) do_op(1'b0, 1'b1, '0,       int'($urandom_range(0, 3)));
      else            do_op(1'b1, 1'b1, $urandom, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
